// File: rtl/dcache_miss_engine.sv
// Direct-mapped, write-back, write-allocate data cache with a word-serial
// miss engine: dirty victim write-back followed by line refill over req/gnt.
module dcache_miss_engine #(
   parameter int LINE_ADDR_LEN = 3,
   parameter int SET_ADDR_LEN  = 3
) (
   input  logic        clk,
   input  logic        CpuRst,
   input  logic        rd_req,
   input  logic        wr_req,
   input  logic [31:0] addr,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   output logic        miss,
   output logic        mem_rd_req,
   output logic        mem_wr_req,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wr_data,
   input  logic [31:0] mem_rd_data,
   input  logic        mem_gnt,
   output logic [1:0]  dbg_state
);

   localparam int TAG_ADDR_LEN = 30 - LINE_ADDR_LEN - SET_ADDR_LEN;
   localparam int WORDS        = 1 << LINE_ADDR_LEN;
   localparam int SETS         = 1 << SET_ADDR_LEN;
   localparam logic [LINE_ADDR_LEN-1:0] CNT_ZERO = '0;
   localparam logic [LINE_ADDR_LEN-1:0] CNT_LAST = '1;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      SWAP_OUT   = 2'd1,
      SWAP_IN    = 2'd2,
      SWAP_IN_OK = 2'd3
   } state_e;

   state_e                    state_q;
   logic [LINE_ADDR_LEN-1:0]  cnt_q;
   logic [LINE_ADDR_LEN-1:0]  cnt_inc;
   logic [TAG_ADDR_LEN-1:0]   req_tag_q;
   logic [SET_ADDR_LEN-1:0]   req_set_q;
   logic [SETS-1:0]           valid_q;
   logic [SETS-1:0]           dirty_q;
   logic [TAG_ADDR_LEN-1:0]   tag_q  [SETS];
   logic [31:0]               line_q [SETS][WORDS];

   logic                      mem_rd_req_q;
   logic                      mem_wr_req_q;
   logic [31:0]               mem_addr_q;
   logic [31:0]               mem_wr_data_q;

   logic [LINE_ADDR_LEN-1:0]  offset;
   logic [SET_ADDR_LEN-1:0]   set_idx;
   logic [TAG_ADDR_LEN-1:0]   tag;
   logic                      hit;
   logic                      req_any;
   logic                      last_beat;
   logic                      unused_addr_bits;

   assign offset           = addr[LINE_ADDR_LEN+1:2];
   assign set_idx          = addr[LINE_ADDR_LEN+SET_ADDR_LEN+1:LINE_ADDR_LEN+2];
   assign tag              = addr[31:32-TAG_ADDR_LEN];
   assign unused_addr_bits = ^addr[1:0];

   assign req_any   = rd_req | wr_req;
   assign hit       = valid_q[set_idx] && (tag_q[set_idx] == tag);
   assign miss      = (state_q != IDLE) || (req_any && !hit);
   assign rd_data   = hit ? line_q[set_idx][offset] : 32'h0;
   assign cnt_inc   = cnt_q + 1'b1;
   assign last_beat = (cnt_q == CNT_LAST);

   assign mem_rd_req  = mem_rd_req_q;
   assign mem_wr_req  = mem_wr_req_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wr_data = mem_wr_data_q;
   assign dbg_state   = state_q;

   function automatic logic [31:0] beat_addr(input logic [TAG_ADDR_LEN-1:0]  t,
                                             input logic [SET_ADDR_LEN-1:0]  s,
                                             input logic [LINE_ADDR_LEN-1:0] c);
      return {t, s, c, 2'b00};
   endfunction

   // Memory outputs are registered, so each transition loads the values for the
   // beat that the next state presents; gnt=0 simply leaves them untouched.
   always_ff @(posedge clk) begin
      if (CpuRst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         req_tag_q     <= '0;
         req_set_q     <= '0;
         valid_q       <= '0;
         dirty_q       <= '0;
         mem_rd_req_q  <= 1'b0;
         mem_wr_req_q  <= 1'b0;
         mem_addr_q    <= '0;
         mem_wr_data_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (wr_req && hit) dirty_q[set_idx] <= 1'b1;
               if (req_any && !hit) begin
                  req_tag_q <= tag;
                  req_set_q <= set_idx;
                  cnt_q     <= '0;
                  if (valid_q[set_idx] && dirty_q[set_idx]) begin
                     state_q       <= SWAP_OUT;
                     mem_wr_req_q  <= 1'b1;
                     mem_addr_q    <= beat_addr(tag_q[set_idx], set_idx, CNT_ZERO);
                     mem_wr_data_q <= line_q[set_idx][CNT_ZERO];
                  end else begin
                     state_q          <= SWAP_IN;
                     valid_q[set_idx] <= 1'b0;
                     mem_rd_req_q     <= 1'b1;
                     mem_addr_q       <= beat_addr(tag, set_idx, CNT_ZERO);
                  end
               end
            end
            SWAP_OUT: begin
               if (mem_gnt) begin
                  if (last_beat) begin
                     cnt_q              <= '0;
                     state_q            <= SWAP_IN;
                     valid_q[req_set_q] <= 1'b0;
                     mem_wr_req_q       <= 1'b0;
                     mem_wr_data_q      <= '0;
                     mem_rd_req_q       <= 1'b1;
                     mem_addr_q         <= beat_addr(req_tag_q, req_set_q, CNT_ZERO);
                  end else begin
                     cnt_q         <= cnt_inc;
                     mem_addr_q    <= beat_addr(tag_q[req_set_q], req_set_q, cnt_inc);
                     mem_wr_data_q <= line_q[req_set_q][cnt_inc];
                  end
               end
            end
            SWAP_IN: begin
               if (mem_gnt) begin
                  cnt_q <= cnt_inc;
                  if (last_beat) begin
                     state_q      <= SWAP_IN_OK;
                     mem_rd_req_q <= 1'b0;
                     mem_addr_q   <= '0;
                  end else begin
                     mem_addr_q <= beat_addr(req_tag_q, req_set_q, cnt_inc);
                  end
               end
            end
            SWAP_IN_OK: begin
               valid_q[req_set_q] <= 1'b1;
               dirty_q[req_set_q] <= 1'b0;
               state_q            <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Data and tag storage carry no reset; validity alone decides a hit.
   always_ff @(posedge clk) begin
      if (!CpuRst) begin
         if (state_q == IDLE && wr_req && hit) line_q[set_idx][offset] <= wr_data;
         if (state_q == SWAP_IN && mem_gnt) line_q[req_set_q][cnt_q] <= mem_rd_data;
         if (state_q == SWAP_IN_OK) tag_q[req_set_q] <= req_tag_q;
      end
   end

endmodule

// File: tb/tb_dcache_miss_engine.sv
// Directed bench for dcache_miss_engine: a word-addressed memory model answers
// the burst handshake and records write-backs so later refills see them.
module tb_dcache_miss_engine;

   logic        clk = 1'b0;
   logic        CpuRst;
   logic        rd_req;
   logic        wr_req;
   logic [31:0] addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        miss;
   logic        mem_rd_req;
   logic        mem_wr_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wr_data;
   logic [31:0] mem_rd_data;
   logic        mem_gnt;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   int miss_cycles;
   bit hold_ok;

   logic [31:0] mem_model [logic [31:0]];
   logic [31:0] exp_q[$];
   logic [31:0] rd_beat_q[$];
   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];

   always #5 clk = ~clk;

   dcache_miss_engine dut (
      .clk         (clk),
      .CpuRst      (CpuRst),
      .rd_req      (rd_req),
      .wr_req      (wr_req),
      .addr        (addr),
      .wr_data     (wr_data),
      .rd_data     (rd_data),
      .miss        (miss),
      .mem_rd_req  (mem_rd_req),
      .mem_wr_req  (mem_wr_req),
      .mem_addr    (mem_addr),
      .mem_wr_data (mem_wr_data),
      .mem_rd_data (mem_rd_data),
      .mem_gnt     (mem_gnt),
      .dbg_state   (dbg_state)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      return a ^ 32'hA5A5_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Presents refill data / captures write-back for the current beat, then
   // advances one clock and returns 1 time unit after the edge.
   task automatic tick();
      if (mem_rd_req === 1'b1) mem_rd_data = mem_word(mem_addr);
      else mem_rd_data = 32'h0;
      if (mem_wr_req === 1'b1 && mem_gnt === 1'b1) mem_model[mem_addr] = mem_wr_data;
      @(posedge clk);
      #1;
   endtask

   task automatic run_miss(input bit toggle, input int budget);
      logic [31:0] prev_addr;
      logic [31:0] prev_wd;
      logic        prev_rd;
      logic        prev_wr;
      bit          prev_hold;
      bit          phase;
      miss_cycles = 0;
      hold_ok     = 1'b1;
      prev_hold   = 1'b0;
      phase       = 1'b1;
      prev_addr   = '0;
      prev_wd     = '0;
      prev_rd     = 1'b0;
      prev_wr     = 1'b0;
      rd_beat_q.delete();
      wr_addr_q.delete();
      wr_data_q.delete();
      while (miss === 1'b1 && miss_cycles < budget) begin
         if (mem_rd_req === 1'b1 && mem_wr_req === 1'b1) hold_ok = 1'b0;
         if (prev_hold && (mem_addr !== prev_addr || mem_wr_data !== prev_wd ||
                           mem_rd_req !== prev_rd || mem_wr_req !== prev_wr)) hold_ok = 1'b0;
         mem_gnt = toggle ? phase : 1'b1;
         phase   = ~phase;
         if (mem_gnt && mem_rd_req === 1'b1) rd_beat_q.push_back(mem_addr);
         if (mem_gnt && mem_wr_req === 1'b1) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wr_data);
         end
         prev_hold = !mem_gnt && (mem_rd_req === 1'b1 || mem_wr_req === 1'b1);
         prev_addr = mem_addr;
         prev_wd   = mem_wr_data;
         prev_rd   = mem_rd_req;
         prev_wr   = mem_wr_req;
         miss_cycles++;
         tick();
      end
      mem_gnt = 1'b1;
   endtask

   task automatic check_rd_beats(input string tag, input logic [31:0] base);
      exp_q.delete();
      for (int i = 0; i < 8; i++) exp_q.push_back(base + 32'(4 * i));
      check({tag, "_count"}, 32'(rd_beat_q.size()), 32'd8);
      while (exp_q.size() > 0 && rd_beat_q.size() > 0)
         check({tag, "_addr"}, rd_beat_q.pop_front(), exp_q.pop_front());
   endtask

   task automatic check_wr_beats(input string tag, input logic [31:0] base,
                                 input int special_idx, input logic [31:0] special_val);
      logic [31:0] a;
      check({tag, "_count"}, 32'(wr_addr_q.size()), 32'd8);
      for (int i = 0; i < 8 && i < wr_addr_q.size(); i++) begin
         a = base + 32'(4 * i);
         check({tag, "_addr"}, wr_addr_q[i], a);
         check({tag, "_data"}, wr_data_q[i], (i == special_idx) ? special_val : (a ^ 32'hA5A5_0000));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      CpuRst      = 1'b1;
      rd_req      = 1'b0;
      wr_req      = 1'b0;
      addr        = 32'h0;
      wr_data     = 32'h0;
      mem_rd_data = 32'h0;
      mem_gnt     = 1'b1;
      tick();
      tick();
      CpuRst = 1'b0;
      #1;
      check("rst_miss", {31'h0, miss}, 32'h0);
      check("rst_mem_rd_req", {31'h0, mem_rd_req}, 32'h0);
      check("rst_mem_wr_req", {31'h0, mem_wr_req}, 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_rd_data", rd_data, 32'h0);
      check("rst_state", {30'h0, dbg_state}, 32'h0);
      tick();

      // Clean miss on 0x104: miss rises the same cycle, 10 cycles total.
      rd_req = 1'b1;
      addr   = 32'h0000_0104;
      #1;
      check("clean_miss_rise", {31'h0, miss}, 32'h1);
      run_miss(1'b0, 50);
      check("clean_miss_cycles", 32'(miss_cycles), 32'd10);
      check("clean_no_wb", 32'(wr_addr_q.size()), 32'd0);
      check_rd_beats("clean_refill", 32'h0000_0100);
      check("clean_rd_data", rd_data, 32'hA5A5_0104);
      check("clean_miss_low", {31'h0, miss}, 32'h0);

      // Write hit, then read it back.
      rd_req  = 1'b0;
      wr_req  = 1'b1;
      addr    = 32'h0000_0108;
      wr_data = 32'hDEAD_BEEF;
      #1;
      check("wr_hit_miss", {31'h0, miss}, 32'h0);
      tick();
      wr_req = 1'b0;
      rd_req = 1'b1;
      #1;
      check("wr_hit_readback", rd_data, 32'hDEAD_BEEF);
      check("wr_hit_rd_miss", {31'h0, miss}, 32'h0);
      tick();

      // Dirty miss on 0x200: write-back of tag 1 then refill of tag 2.
      addr = 32'h0000_0200;
      #1;
      run_miss(1'b0, 60);
      check("dirty_miss_cycles", 32'(miss_cycles), 32'd18);
      check("dirty_hold_excl", {31'h0, hold_ok}, 32'h1);
      check_wr_beats("dirty_wb", 32'h0000_0100, 2, 32'hDEAD_BEEF);
      check_rd_beats("dirty_refill", 32'h0000_0200);
      check("dirty_rd_data", rd_data, 32'hA5A5_0200);

      // Dirty the tag-2 line, then miss back to tag 1 with gnt alternating.
      rd_req  = 1'b0;
      wr_req  = 1'b1;
      addr    = 32'h0000_0204;
      wr_data = 32'h1234_5678;
      #1;
      tick();
      wr_req = 1'b0;
      rd_req = 1'b1;
      addr   = 32'h0000_010C;
      #1;
      run_miss(1'b1, 120);
      check("toggle_miss_done", {31'h0, miss}, 32'h0);
      check("toggle_hold", {31'h0, hold_ok}, 32'h1);
      check_wr_beats("toggle_wb", 32'h0000_0200, 1, 32'h1234_5678);
      check_rd_beats("toggle_refill", 32'h0000_0100);
      check("toggle_rd_10c", rd_data, 32'hA5A5_010C);
      tick();
      addr = 32'h0000_0108;
      #1;
      check("toggle_rd_108", rd_data, 32'hDEAD_BEEF);
      tick();

      // Reset during refill beat 3 of a clean miss on 0x300.
      addr = 32'h0000_0300;
      #1;
      k = 0;
      while (!(mem_rd_req === 1'b1 && mem_addr === 32'h0000_030C) && k < 20) begin
         tick();
         k++;
      end
      check("rst_mid_beat3", mem_addr, 32'h0000_030C);
      CpuRst = 1'b1;
      rd_req = 1'b0;
      tick();
      CpuRst = 1'b0;
      #1;
      check("rst_mid_rd_req", {31'h0, mem_rd_req}, 32'h0);
      check("rst_mid_wr_req", {31'h0, mem_wr_req}, 32'h0);
      check("rst_mid_addr", mem_addr, 32'h0);
      check("rst_mid_miss", {31'h0, miss}, 32'h0);
      rd_req = 1'b1;
      addr   = 32'h0000_0104;
      #1;
      check("rst_reread_miss", {31'h0, miss}, 32'h1);
      run_miss(1'b0, 50);
      check("rst_reread_cycles", 32'(miss_cycles), 32'd10);
      check_rd_beats("rst_reread_refill", 32'h0000_0100);

      // Back-to-back hits across the whole line.
      for (int i = 0; i < 8; i++) begin
         addr = 32'h0000_0100 + 32'(4 * i);
         #1;
         check("b2b_miss", {31'h0, miss}, 32'h0);
         check("b2b_rd_data", rd_data, (i == 2) ? 32'hDEAD_BEEF : (addr ^ 32'hA5A5_0000));
         tick();
      end
      rd_req = 1'b0;
      #1;
      check("idle_no_req_miss", {31'h0, miss}, 32'h0);
      check("idle_state", {30'h0, dbg_state}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
